// File: rtl/imem_load_arb.sv
// imem_load_arb: instruction-memory port arbiter and byte-serial program loader.
// Shares the single 256x16 memory port between fetch (read) and the loader (write).
//
// Parameters:
//   BOOT_LOAD    1 = come out of reset in LOAD_HI with the CPU stalled.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   cpu_addr     fetch address in; cpu_q instruction out; cpu_stall freezes fetch
//   load_start   one-cycle session request (honoured only in RUN)
//   ld_data      loader byte in; qualified by ld_valid and ld_ready
//   ld_last      final-byte flag, sampled with a low byte
//   load_done    one-cycle pulse at session end
//   words_loaded word count of the last session (0..256)
//   load_sum     16-bit additive checksum of written words
//   mem_*        memory address, write data, write enable, async read data
// Build option: define IMEM_CHECKSUM_EN to build the load_sum accumulator;
// otherwise load_sum reads 16'h0000.
module imem_load_arb #(
  parameter bit BOOT_LOAD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cpu_addr,
  output logic [15:0] cpu_q,
  output logic        cpu_stall,
  input  logic        load_start,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        ld_last,
  output logic        load_done,
  output logic [8:0]  words_loaded,
  output logic [15:0] load_sum,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_q
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WRITE   = 3'd3,
    FLUSH   = 3'd4
  } state_t;

  localparam state_t RST_STATE = BOOT_LOAD ? LOAD_HI : RUN;

  state_t     state;
  logic [7:0] wr_ptr;
  logic [7:0] hi;
  logic [7:0] lo;
  logic       last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RST_STATE;
      wr_ptr       <= 8'd0;
      words_loaded <= 9'd0;
      hi           <= 8'd0;
      lo           <= 8'd0;
      last_q       <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (load_start) begin
            state        <= LOAD_HI;
            wr_ptr       <= 8'd0;
            words_loaded <= 9'd0;
            last_q       <= 1'b0;
          end
        end
        LOAD_HI: begin
          if (ld_valid) begin
            hi    <= ld_data;
            state <= LOAD_LO;
          end
        end
        LOAD_LO: begin
          if (ld_valid) begin
            lo     <= ld_data;
            last_q <= ld_last;
            state  <= WRITE;
          end
        end
        WRITE: begin
          wr_ptr       <= wr_ptr + 8'd1;
          words_loaded <= words_loaded + 9'd1;
          // wr_ptr == 255 means the word just written filled the memory
          if (last_q || (wr_ptr == 8'hFF)) begin
            state <= FLUSH;
          end else begin
            state  <= LOAD_HI;
            last_q <= 1'b0;
          end
        end
        FLUSH: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sum <= 16'h0000;
    end else if ((state == RUN) && load_start) begin
      load_sum <= 16'h0000;
    end else if (state == WRITE) begin
      load_sum <= load_sum + {hi, lo};
    end
  end
`else
  assign load_sum = 16'h0000;
`endif

  // Outputs decode straight from the state register.
  assign cpu_stall = (state != RUN);
  assign ld_ready  = (state == LOAD_HI) || (state == LOAD_LO);
  assign mem_we    = (state == WRITE);
  assign load_done = (state == FLUSH);
  assign mem_addr  = (state == WRITE) ? wr_ptr : cpu_addr;
  assign mem_wdata = {hi, lo};
  assign cpu_q     = mem_q;

endmodule

// File: tb/tb_imem_load_arb.sv
// tb_imem_load_arb: directed bench for imem_load_arb with a behavioural
// 256x16 async-read memory; expected values are hand-computed constants.
module tb_imem_load_arb;

  logic        clk;
  logic        rst_n;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_q;
  logic        cpu_stall;
  logic        load_start;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_last;
  logic        load_done;
  logic [8:0]  words_loaded;
  logic [15:0] load_sum;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_q;

  logic [15:0] mem [256];

  int tests;
  int fails;
  int done_cnt;
  int wr_cnt;
  int bad_we;
  int bad_rdy;
  logic [7:0] last_wa;

  imem_load_arb #(.BOOT_LOAD(1'b0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_q        (cpu_q),
    .cpu_stall    (cpu_stall),
    .load_start   (load_start),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_last      (ld_last),
    .load_done    (load_done),
    .words_loaded (words_loaded),
    .load_sum     (load_sum),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_q        (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_q = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_wa       <= mem_addr;
    end
    if (load_done) done_cnt <= done_cnt + 1;
    if (mem_we && !cpu_stall) bad_we <= bad_we + 1;
    if (mem_we && ld_ready) bad_rdy <= bad_rdy + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Offer one byte after an optional idle gap; returns once it transferred.
  task automatic send(input logic [7:0] d, input logic l, input int gap);
    int n;
    ld_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    ld_data  = d;
    ld_last  = l;
    ld_valid = 1'b1;
    n = 0;
    while (!ld_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("handshake_timeout", 32'd0, 32'd1);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  logic [15:0] exp_sum;
  int          wr0;

  initial begin
    tests = 0; fails = 0; done_cnt = 0; wr_cnt = 0;
    bad_we = 0; bad_rdy = 0; last_wa = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h3C] = 16'hBEEF;
    rst_n = 1'b0; cpu_addr = 8'h3C; load_start = 1'b0;
    ld_data = 8'h00; ld_valid = 1'b0; ld_last = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // reset state and zero-latency fetch path
    check("rst_stall", cpu_stall, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_done", load_done, 0);
    check("rst_words", words_loaded, 0);
    check("rst_sum", load_sum, 0);
    check("run_addr", mem_addr, 8'h3C);
    check("run_q", cpu_q, 16'hBEEF);

    // basic two-word load
    start();
    check("hi_ready", ld_ready, 1);
    check("hi_stall", cpu_stall, 1);
    send(8'h12, 1'b0, 0);
    send(8'h34, 1'b0, 0);
    check("write_we", mem_we, 1);
    check("write_addr", mem_addr, 8'h00);
    check("write_ready", ld_ready, 0);
    send(8'h56, 1'b0, 0);
    send(8'h78, 1'b1, 0);
    tick();
    check("flush_done", load_done, 1);
    check("flush_stall", cpu_stall, 1);
    check("flush_addr", mem_addr, 8'h3C);
    tick();
    check("run_stall", cpu_stall, 0);
    check("mem0", mem[0], 16'h1234);
    check("mem1", mem[1], 16'h5678);
    check("done_cnt", done_cnt, 1);
    check("words2", words_loaded, 2);
`ifdef IMEM_CHECKSUM_EN
    exp_sum = 16'h68AC;
`else
    exp_sum = 16'h0000;
`endif
    check("sum2", load_sum, exp_sum);
    cpu_addr = 8'h01;
    #1;
    check("fetch_new", cpu_q, 16'h5678);

    // four words with random ld_valid gaps
    start();
    send(8'hA1, 1'b0, $urandom_range(0, 3));
    send(8'hA2, 1'b0, $urandom_range(0, 3));
    send(8'hA3, 1'b0, $urandom_range(0, 3));
    send(8'hA4, 1'b0, $urandom_range(0, 3));
    send(8'hA5, 1'b0, $urandom_range(0, 3));
    send(8'hA6, 1'b0, $urandom_range(0, 3));
    send(8'hA7, 1'b0, $urandom_range(0, 3));
    send(8'hA8, 1'b1, $urandom_range(0, 3));
    tick(); tick();
    check("r_mem0", mem[0], 16'hA1A2);
    check("r_mem1", mem[1], 16'hA3A4);
    check("r_mem2", mem[2], 16'hA5A6);
    check("r_mem3", mem[3], 16'hA7A8);
    check("r_words", words_loaded, 4);
`ifdef IMEM_CHECKSUM_EN
    exp_sum = 16'h9294;
`else
    exp_sum = 16'h0000;
`endif
    check("r_sum", load_sum, exp_sum);
    check("r_done_cnt", done_cnt, 2);

    // fill the memory: 512 bytes, no ld_last
    start();
    wr0 = wr_cnt;
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 1'b0, 0);
      send(~8'(i), 1'b0, 0);
    end
    tick();
    check("full_flush", load_done, 1);
    check("full_wr_cnt", wr_cnt - wr0, 256);
    check("full_last_addr", last_wa, 8'hFF);
    tick();
    check("full_words", words_loaded, 9'd256);
    check("full_mem0", mem[0], 16'h00FF);
    check("full_mem255", mem[255], 16'hFF00);
`ifdef IMEM_CHECKSUM_EN
    exp_sum = 16'hFF80;
`else
    exp_sum = 16'h0000;
`endif
    check("full_sum", load_sum, exp_sum);
    ld_valid = 1'b1;
    ld_data  = 8'h55;
    tick(); tick();
    check("full_ready_low", ld_ready, 0);
    check("full_stall_low", cpu_stall, 0);
    ld_valid = 1'b0;

    // ld_last on a high byte is ignored
    start();
    send(8'h11, 1'b1, 0);
    send(8'h22, 1'b0, 0);
    tick();
    check("hilast_nodone", load_done, 0);
    check("hilast_ready", ld_ready, 1);
    send(8'h33, 1'b0, 0);
    send(8'h44, 1'b1, 0);
    tick(); tick();
    check("hilast_words", words_loaded, 2);
    check("hilast_mem1", mem[1], 16'h3344);

    // reset in LOAD_LO after one word is written
    start();
    send(8'h9A, 1'b0, 0);
    send(8'hBC, 1'b0, 0);
    send(8'hDE, 1'b0, 0);
    check("pre_rst_ready", ld_ready, 1);
    rst_n = 1'b0;
    #1;
    check("arst_stall", cpu_stall, 0);
    check("arst_ready", ld_ready, 0);
    check("arst_words", words_loaded, 0);
    check("arst_wdata", mem_wdata, 0);
    check("arst_mem0", mem[0], 16'h9ABC);
    tick();
    rst_n = 1'b1;
    tick();

    // load_start during LOAD_HI must not restart the pointer
    start();
    send(8'hF0, 1'b0, 0);
    send(8'h0F, 1'b0, 0);
    tick();
    start();
    send(8'h13, 1'b0, 0);
    send(8'h57, 1'b1, 0);
    tick(); tick();
    check("ign_words", words_loaded, 2);
    check("ign_mem0", mem[0], 16'hF00F);
    check("ign_mem1", mem[1], 16'h1357);
    check("we_in_run", bad_we, 0);
    check("ready_in_write", bad_rdy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
